uart_tx_serializer: RTL and testbench

- UART transmit serializer sitting directly downstream of the TX FIFO storage array.
- Pops one word whenever the FIFO is non-empty and transmission is enabled, then shifts it out as an asynchronous serial frame: start bit, data LSB-first, optional parity, 1 or 2 stop bits.
- Consumes the FIFO's combinational read data. Issues the pop strobe that the FIFO pointer logic uses to advance the read pointer.

---
 rtl/uart_tx_serializer_if.sv | 18 +
 rtl/uart_tx_serializer.sv | 153 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_serializer_if
// Brief    : TX FIFO read port (empty flag, combinational read data, pop).
// Revision : 1.0
// ============================================================================
interface uart_tx_serializer_if #(
  parameter int WIDTH = 8
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_pop;

  // master = FIFO side, slave = serializer side
  modport master (output fifo_empty, output fifo_data, input fifo_pop);
  modport slave  (input fifo_empty, input fifo_data, output fifo_pop);
endinterface
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_serializer
// Brief    : Pops words from the TX FIFO and shifts them out as UART frames.
// Revision : 1.0
// ============================================================================
module uart_tx_serializer #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0,
  parameter int STOP_BITS    = 1
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  input  wire logic           tx_en,
  uart_tx_serializer_if.slave fifo,
  output logic                tx,
  output logic                busy
);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_stop_idx;
  logic [WIDTH-1:0] r_shift;
  logic             r_tx;
  logic             r_busy;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_stop_idx_nxt;
  logic [WIDTH-1:0] w_shift_nxt;
  logic             w_tx_nxt;
  logic             w_pop;
  logic             w_pop_ok;
  logic             w_bit_end;
  logic             w_last_stop;

  assign w_bit_end   = (r_cnt == c_cnt_last);
  assign w_last_stop = (STOP_BITS < 2) ? 1'b1 : r_stop_idx;
  // rst_n gating keeps the pop strobe low while the block is held in reset
  assign w_pop_ok    = rst_n & tx_en & ~fifo.fifo_empty;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = w_bit_end ? '0 : r_cnt + 1'b1;
    w_idx_nxt      = r_idx;
    w_stop_idx_nxt = r_stop_idx;
    w_shift_nxt    = r_shift;
    w_pop          = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_pop_ok) begin
          w_pop       = 1'b1;
          w_shift_nxt = fifo.fifo_data;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_idx_nxt   = '0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_idx == c_idx_last) begin
            w_state_nxt    = PARITY_EN ? S_PARITY : S_STOP;
            w_stop_idx_nxt = 1'b0;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt    = S_STOP;
          w_stop_idx_nxt = 1'b0;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (!w_last_stop) begin
            w_stop_idx_nxt = 1'b1;
          end else if (w_pop_ok) begin
            // gapless back-to-back: next start bit follows the last stop bit
            w_pop       = 1'b1;
            w_shift_nxt = fifo.fifo_data;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // tx is registered, so its value is derived from the next-state view
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[w_idx_nxt];
      S_PARITY: w_tx_nxt = (^w_shift_nxt) ^ PARITY_ODD;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_stop_idx <= w_stop_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  assign fifo.fifo_pop = w_pop;
  assign tx            = r_tx;
  assign busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_serializer
// Brief    : Three parameter sets, FIFO model and a frame-decoding scoreboard.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_serializer;
  localparam int CPB   = 4;
  localparam int N_DUT = 3;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
  } exp_t;
  typedef logic [7:0] byte_q_t [$];
  typedef exp_t       exp_q_t  [$];

  logic             clk = 1'b0;
  logic             rst_n;
  logic             tx_en;
  logic             fe [N_DUT];
  logic [7:0]       fd [N_DUT];
  logic [N_DUT-1:0] pop_w;
  logic [N_DUT-1:0] tx_w;
  logic [N_DUT-1:0] busy_w;
  byte_q_t          fifo_q [N_DUT];
  exp_q_t           exp_q  [N_DUT];
  int               pop_cnt  [N_DUT] = '{default: 0};
  int               pop_last [N_DUT] = '{default: 0};
  int               pop_prev [N_DUT] = '{default: 0};
  int               cyc      = 0;
  int               n_checks = 0;
  int               n_err    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic refresh(input int i);
    fe[i] = (fifo_q[i].size() == 0);
    fd[i] = fe[i] ? 8'h00 : fifo_q[i][0];
  endtask

  task automatic push(input int i, input logic [7:0] d, input bit do_exp, input logic par);
    exp_t e;
    fifo_q[i].push_back(d);
    if (do_exp) begin
      e.data = d;
      e.par  = par;
      exp_q[i].push_back(e);
    end
    refresh(i);
  endtask

  task automatic measure_busy(input int i, output int n);
    n = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (busy_w[i] !== 1'b1) break;
      n++;
    end
  endtask

  for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
    localparam bit PE = (gi != 0);
    localparam bit PO = (gi == 2);
    localparam int NS = (gi == 0) ? 1 : 2;
    localparam int NB = 1 + 8 + int'(PE) + NS;

    uart_tx_serializer_if #(.WIDTH(8)) ifc ();
    assign ifc.fifo_empty = fe[gi];
    assign ifc.fifo_data  = fd[gi];
    assign pop_w[gi]      = ifc.fifo_pop;

    uart_tx_serializer #(
      .WIDTH       (8),
      .CLKS_PER_BIT(CPB),
      .PARITY_EN   (PE),
      .PARITY_ODD  (PO),
      .STOP_BITS   (NS)
    ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .tx_en(tx_en),
      .fifo (ifc),
      .tx   (tx_w[gi]),
      .busy (busy_w[gi])
    );

    // FIFO model: pop sampled just before the edge, pointer advanced after it
    initial begin : p_fifo
      logic       p;
      logic       e;
      logic [7:0] dump;
      forever begin
        @(negedge clk);
        #4;
        p = pop_w[gi];
        e = fe[gi];
        @(posedge clk);
        #1;
        if (p) begin
          chk($sformatf("dut%0d_pop_not_empty", gi), 32'(e), 32'd0);
          if (!e) dump = fifo_q[gi].pop_front();
          pop_cnt[gi]++;
          pop_prev[gi] = pop_last[gi];
          pop_last[gi] = cyc;
          refresh(gi);
        end
      end
    end

    // Line monitor: decodes each frame mid-bit and checks it against the queue
    initial begin : p_mon
      logic [11:0] got;
      logic [11:0] want;
      exp_t        e;
      bit          aborted;
      forever begin
        @(negedge tx_w[gi]);
        if (rst_n !== 1'b1) continue;
        got     = '0;
        aborted = 1'b0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NB; k++) begin
          if (k != 0) repeat (CPB) @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          got[k] = tx_w[gi];
        end
        if (aborted) continue;
        chk($sformatf("dut%0d_frame_expected", gi), 32'(exp_q[gi].size() != 0), 32'd1);
        if (exp_q[gi].size() != 0) begin
          e        = exp_q[gi].pop_front();
          want     = '1;
          want[0]  = 1'b0;
          want[8:1] = e.data;
          want[9]  = PE ? e.par : 1'b1;
          want     = want & 12'((1 << NB) - 1);
          chk($sformatf("dut%0d_frame_%02h", gi, e.data), 32'(got), 32'(want));
        end
      end
    end
  end

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin : p_main
    int         bad;
    int         nb;
    int         p0;
    logic [9:0] a5_seq;
    a5_seq = 10'b11_0100_1010;
    rst_n  = 1'b0;
    tx_en  = 1'b1;
    for (int i = 0; i < N_DUT; i++) refresh(i);

    // Reset with a non-empty FIFO, then a single 0xA5 frame
    push(0, 8'hA5, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx_w[0]), 32'd1);
    chk("rst_busy", 32'(busy_w[0]), 32'd0);
    chk("rst_pop", 32'(pop_w[0]), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("release_pop", 32'(pop_w[0]), 32'd1);
    bad = 0;
    nb  = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (tx_w[0] !== a5_seq[c / CPB]) bad++;
      if (busy_w[0] === 1'b1) nb++;
    end
    chk("a5_tx_seq_bad", bad, 0);
    chk("a5_busy_cycles", nb, 40);
    @(negedge clk);
    chk("a5_end_tx", 32'(tx_w[0]), 32'd1);
    chk("a5_end_busy", 32'(busy_w[0]), 32'd0);
    chk("a5_pop_count", pop_cnt[0], 1);

    // Back-to-back 0x00, 0xFF
    push(0, 8'h00, 1'b1, 1'b0);
    push(0, 8'hFF, 1'b1, 1'b0);
    measure_busy(0, nb);
    chk("b2b_busy_cycles", nb, 80);
    chk("b2b_pop_count", pop_cnt[0], 3);
    chk("b2b_pop_spacing", pop_last[0] - pop_prev[0], 40);

    // Parity, two stop bits: even on dut1, odd on dut2
    push(1, 8'h07, 1'b1, 1'b1);
    push(2, 8'h07, 1'b1, 1'b0);
    bad = 0;
    nb  = 0;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      if (busy_w[1] === 1'b1 && busy_w[2] === 1'b1) nb++;
      if (c >= 40 && (tx_w[1] !== 1'b1 || tx_w[2] !== 1'b1)) bad++;
      if (c >= 36 && c < 40 && (tx_w[1] !== 1'b1 || tx_w[2] !== 1'b0)) bad++;
    end
    chk("par_busy_cycles", nb, 48);
    chk("par_stop_parity_bad", bad, 0);
    @(negedge clk);
    chk("par_end_busy", 32'({busy_w[1], busy_w[2]}), 32'd0);
    chk("par_pop_count_even", pop_cnt[1], 1);
    chk("par_pop_count_odd", pop_cnt[2], 1);

    // Gating: empty FIFO, then tx_en low, then tx_en dropped mid-frame
    p0  = pop_cnt[0];
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || pop_w[0] !== 1'b0) bad++;
    end
    chk("empty_idle_bad", bad, 0);
    chk("empty_no_pop", pop_cnt[0], p0);
    tx_en = 1'b0;
    push(0, 8'h3C, 1'b1, 1'b0);
    push(0, 8'h81, 1'b0, 1'b0);
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1 || pop_w[0] !== 1'b0) bad++;
    end
    chk("txen_off_bad", bad, 0);
    chk("txen_off_no_pop", pop_cnt[0], p0);
    tx_en = 1'b1;
    #1;
    chk("txen_on_pop", 32'(pop_w[0]), 32'd1);
    nb = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 17) tx_en = 1'b0;
      if (busy_w[0] !== 1'b1) break;
      nb++;
    end
    chk("txen_drop_busy", nb, 40);
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (tx_w[0] !== 1'b1) bad++;
    end
    chk("txen_drop_idle_bad", bad, 0);
    chk("txen_drop_pop_count", pop_cnt[0], p0 + 1);

    // Reset during data bit 4 of 0x81, then a fresh 0x5A frame
    tx_en = 1'b1;
    #1;
    chk("rst6_pop", 32'(pop_w[0]), 32'd1);
    for (int c = 0; c < 22; c++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst6_tx", 32'(tx_w[0]), 32'd1);
    chk("rst6_busy", 32'(busy_w[0]), 32'd0);
    push(0, 8'h5A, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    chk("rst6_hold_pop", 32'(pop_w[0]), 32'd0);
    chk("rst6_pop_count", pop_cnt[0], p0 + 2);
    rst_n = 1'b1;
    #1;
    chk("rst6_release_pop", 32'(pop_w[0]), 32'd1);
    measure_busy(0, nb);
    chk("rst6_busy_cycles", nb, 40);
    chk("rst6_pop_count_after", pop_cnt[0], p0 + 3);
    chk("rst6_fifo_drained", fifo_q[0].size(), 0);

    repeat (10) @(negedge clk);
    for (int i = 0; i < N_DUT; i++) begin
      chk($sformatf("dut%0d_frames_left", i), exp_q[i].size(), 0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
